// File: rtl/icache_assoc_pkg.sv
// Shared constants, derived address-field widths and FSM encoding for the
// set-associative instruction cache.
package icache_assoc_pkg;

    localparam int ICACHE_NUM_SETS   = 64;
    localparam int ICACHE_NUM_WAYS   = 2;
    localparam int ICACHE_LINE_BYTES = 16;

    localparam int ICACHE_OFF_W = $clog2(ICACHE_LINE_BYTES);
    localparam int ICACHE_IDX_W = $clog2(ICACHE_NUM_SETS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_OFF_W - ICACHE_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REFILL = 2'b01,
        ST_DRAIN  = 2'b10
    } icache_state_e;

    // Clears the byte-offset bits so the result points at the start of the line.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int off_w);
        return addr & ~((32'd1 << off_w) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_way_array.sv
// One way of the cache: per-set tag, valid bit and line data, two combinational
// read ports and a single full-line write port.
module icache_way_array #(
    parameter int NUM_SETS   = 64,
    parameter int LINE_BYTES = 16
) (
    input  logic                                             clk_in,
    input  logic                                             rst_in,
    input  logic                                             inv_all,
    input  logic                                             wr_en,
    input  logic [$clog2(NUM_SETS)-1:0]                      wr_idx,
    input  logic [32-$clog2(LINE_BYTES)-$clog2(NUM_SETS)-1:0] wr_tag,
    input  logic [LINE_BYTES*8-1:0]                          wr_line,
    input  logic [$clog2(NUM_SETS)-1:0]                      rd_idx_a,
    input  logic [$clog2(NUM_SETS)-1:0]                      rd_idx_b,
    output logic                                             rd_valid_a,
    output logic [32-$clog2(LINE_BYTES)-$clog2(NUM_SETS)-1:0] rd_tag_a,
    output logic [LINE_BYTES*8-1:0]                          rd_line_a,
    output logic                                             rd_valid_b,
    output logic [32-$clog2(LINE_BYTES)-$clog2(NUM_SETS)-1:0] rd_tag_b,
    output logic [LINE_BYTES*8-1:0]                          rd_line_b
);

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - $clog2(LINE_BYTES) - IDX_W;
    localparam int LINE_W = LINE_BYTES * 8;

    logic [NUM_SETS-1:0] valid_r;
    logic [TAG_W-1:0]    tag_mem_r  [NUM_SETS];
    logic [LINE_W-1:0]   data_mem_r [NUM_SETS];

    // Valid bits: a whole-cache invalidate beats a simultaneous install.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_r <= '0;
        end else if (inv_all) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; the valid bit guards them.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_mem_r[wr_idx]  <= wr_tag;
            data_mem_r[wr_idx] <= wr_line;
        end
    end

    assign rd_valid_a = valid_r[rd_idx_a];
    assign rd_tag_a   = tag_mem_r[rd_idx_a];
    assign rd_line_a  = data_mem_r[rd_idx_a];
    assign rd_valid_b = valid_r[rd_idx_b];
    assign rd_tag_b   = tag_mem_r[rd_idx_b];
    assign rd_line_b  = data_mem_r[rd_idx_b];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: lookup of 16/32-bit instructions (including
// line-straddling ones), single-line refill FSM with drain, round-robin replacement.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int NUM_SETS   = ICACHE_NUM_SETS,
    parameter int NUM_WAYS   = ICACHE_NUM_WAYS,
    parameter int LINE_BYTES = ICACHE_LINE_BYTES
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        need_flush_in,
    input  logic        invalidate_in,
    input  logic        if_valid,
    input  logic [31:0] if_instr_addr,
    output logic        hit_out,
    output logic [31:0] instr_out,
    output logic        busy_out,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_busy,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WORDS  = LINE_BYTES / 4;
    localparam int HWS    = LINE_BYTES / 2;
    localparam int HW_W   = OFF_W - 1;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    icache_state_e     state_r;
    icache_state_e     state_next_s;
    logic [BEAT_W-1:0] beat_r;
    logic [LINE_W-1:0] line_buf_r;
    logic [LINE_W-1:0] fill_line_s;
    logic [WAY_W-1:0]  rr_ptr_r [NUM_SETS];
    logic              mem_req_r;
    logic              busy_r;
    logic [31:0]       mem_addr_r;

    logic [31:0]       addr_b_s;
    logic [IDX_W-1:0]  idx_a_s, idx_b_s, fill_idx_s, rd_idx_a_s;
    logic [TAG_W-1:0]  tag_a_s, tag_b_s, fill_tag_s;
    logic [HW_W-1:0]   hw_a_s, hw_b_s;
    logic              unused_addr_s;

    logic [NUM_WAYS-1:0] way_valid_a_s, way_valid_b_s, way_we_s;
    logic [TAG_W-1:0]    way_tag_a_s  [NUM_WAYS];
    logic [TAG_W-1:0]    way_tag_b_s  [NUM_WAYS];
    logic [LINE_W-1:0]   way_line_a_s [NUM_WAYS];
    logic [LINE_W-1:0]   way_line_b_s [NUM_WAYS];

    logic              hit_a_s, hit_b_s, is32_s, lookup_s, hit_s, miss_s;
    logic [LINE_W-1:0] line_a_s, line_b_s;
    logic [15:0]       h0_s, h1_s;
    logic [31:0]       miss_addr_s;
    logic              last_beat_s, install_s, inv_s, victim_found_s;
    logic [WAY_W-1:0]  victim_s, rr_next_s;

    assign addr_b_s      = if_instr_addr + 32'd2;
    assign idx_a_s       = if_instr_addr[OFF_W +: IDX_W];
    assign tag_a_s       = if_instr_addr[31 -: TAG_W];
    assign hw_a_s        = if_instr_addr[OFF_W-1:1];
    assign idx_b_s       = addr_b_s[OFF_W +: IDX_W];
    assign tag_b_s       = addr_b_s[31 -: TAG_W];
    assign hw_b_s        = addr_b_s[OFF_W-1:1];
    assign fill_idx_s    = mem_addr_r[OFF_W +: IDX_W];
    assign fill_tag_s    = mem_addr_r[31 -: TAG_W];
    assign unused_addr_s = ^{if_instr_addr[0], addr_b_s[0]};

    // Port A serves the fetch lookup in IDLE and the victim search during refill.
    assign rd_idx_a_s = (state_r == ST_IDLE) ? idx_a_s : fill_idx_s;
    assign inv_s      = rdy_in & invalidate_in;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        icache_way_array #(
            .NUM_SETS   (NUM_SETS),
            .LINE_BYTES (LINE_BYTES)
        ) u_way (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .inv_all    (inv_s),
            .wr_en      (way_we_s[w]),
            .wr_idx     (fill_idx_s),
            .wr_tag     (fill_tag_s),
            .wr_line    (fill_line_s),
            .rd_idx_a   (rd_idx_a_s),
            .rd_idx_b   (idx_b_s),
            .rd_valid_a (way_valid_a_s[w]),
            .rd_tag_a   (way_tag_a_s[w]),
            .rd_line_a  (way_line_a_s[w]),
            .rd_valid_b (way_valid_b_s[w]),
            .rd_tag_b   (way_tag_b_s[w]),
            .rd_line_b  (way_line_b_s[w])
        );
    end

    // Tag compare and one-hot OR-mux of the hitting way for both lookup lines.
    always_comb begin
        hit_a_s  = 1'b0;
        hit_b_s  = 1'b0;
        line_a_s = '0;
        line_b_s = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_valid_a_s[w] && (way_tag_a_s[w] == tag_a_s)) begin
                hit_a_s  = 1'b1;
                line_a_s = line_a_s | way_line_a_s[w];
            end else begin
                line_a_s = line_a_s;
            end
            if (way_valid_b_s[w] && (way_tag_b_s[w] == tag_b_s)) begin
                hit_b_s  = 1'b1;
                line_b_s = line_b_s | way_line_b_s[w];
            end else begin
                line_b_s = line_b_s;
            end
        end
    end

    // Halfword extraction at A (from line A) and A+2 (from line B).
    always_comb begin
        h0_s = 16'h0000;
        h1_s = 16'h0000;
        for (int i = 0; i < HWS; i++) begin
            if (hw_a_s == HW_W'(i)) begin
                h0_s = line_a_s[i*16 +: 16];
            end else begin
                h0_s = h0_s;
            end
            if (hw_b_s == HW_W'(i)) begin
                h1_s = line_b_s[i*16 +: 16];
            end else begin
                h1_s = h1_s;
            end
        end
    end

    assign lookup_s    = (state_r == ST_IDLE) && if_valid;
    assign is32_s      = (h0_s[1:0] == 2'b11);
    assign hit_s       = lookup_s && hit_a_s && (!is32_s || hit_b_s);
    assign miss_s      = lookup_s && !hit_s;
    assign miss_addr_s = hit_a_s ? line_base(addr_b_s, OFF_W) : line_base(if_instr_addr, OFF_W);
    assign hit_out     = hit_s;
    assign instr_out   = !hit_s ? 32'h0000_0000 : (is32_s ? {h1_s, h0_s} : {16'h0000, h0_s});

    assign last_beat_s = (beat_r == BEAT_W'(WORDS - 1));
    assign install_s   = rdy_in && (state_r == ST_REFILL) && mem_valid && last_beat_s;

    // Next-state logic of the refill/drain FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (miss_s && !need_flush_in && !mem_busy) begin
                    state_next_s = ST_REFILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if (mem_valid && last_beat_s) begin
                    state_next_s = ST_IDLE;
                end else if (need_flush_in) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_REFILL;
                end
            end
            ST_DRAIN: begin
                if (mem_valid && last_beat_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Merge the current beat into the line buffer; on the last beat this is the line to install.
    always_comb begin
        fill_line_s = line_buf_r;
        for (int i = 0; i < WORDS; i++) begin
            if (beat_r == BEAT_W'(i)) begin
                fill_line_s[i*32 +: 32] = mem_data;
            end else begin
                fill_line_s = fill_line_s;
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim_s       = rr_ptr_r[fill_idx_s];
        victim_found_s = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!victim_found_s && !way_valid_a_s[w]) begin
                victim_s       = WAY_W'(w);
                victim_found_s = 1'b1;
            end else begin
                victim_s = victim_s;
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_we_s[w] = install_s && (victim_s == WAY_W'(w));
        end
    end

    assign rr_next_s = (rr_ptr_r[fill_idx_s] == WAY_W'(NUM_WAYS - 1)) ?
                       WAY_W'(0) : (rr_ptr_r[fill_idx_s] + WAY_W'(1));

    // FSM state, beat counter, line buffer and registered memory-side outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            beat_r     <= '0;
            line_buf_r <= '0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
            busy_r     <= 1'b0;
        end else if (rdy_in) begin
            state_r   <= state_next_s;
            mem_req_r <= (state_r == ST_IDLE) && (state_next_s == ST_REFILL);
            busy_r    <= (state_next_s != ST_IDLE);
            if ((state_r == ST_IDLE) && (state_next_s == ST_REFILL)) begin
                mem_addr_r <= miss_addr_s;
            end
            if (state_r == ST_IDLE) begin
                beat_r <= '0;
            end else if (mem_valid) begin
                beat_r <= last_beat_s ? BEAT_W'(0) : (beat_r + BEAT_W'(1));
            end
            if ((state_r == ST_REFILL) && mem_valid) begin
                line_buf_r <= fill_line_s;
            end
        end
    end

    // Round-robin pointers advance on every install into their set.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr_r[s] <= '0;
            end
        end else if (install_s) begin
            rr_ptr_r[fill_idx_s] <= rr_next_s;
        end
    end

    assign mem_req_out  = mem_req_r;
    assign mem_addr_out = mem_addr_r;
    assign busy_out     = busy_r;

endmodule
